// File: rtl/objective.sv
// objective: output-layer endpoint; clamps products in inference, returns saturated
// error terms to the node in training and keeps running error statistics.
module objective #(
   parameter int S = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        train,
   input  logic        clear,
   input  logic        product_valid,
   input  logic [15:0] product_data,
   output logic        product_ready,
   input  logic        target_valid,
   input  logic [7:0]  target_data,
   output logic        target_ready,
   output logic        delta_valid,
   output logic [15:0] delta_data,
   input  logic        delta_ready,
   output logic        result_valid,
   output logic [7:0]  result_data,
   input  logic        result_ready,
   output logic [31:0] error_sum,
   output logic [15:0] sample_count
);
   localparam logic [2:0] IDLE = 3'd0, RES = 3'd1, TGT = 3'd2, CMP = 3'd3, DEL = 3'd4;
   logic [2:0] state;
   logic [15:0] prod;
   logic [7:0] tgt;
   logic signed [16:0] diff;
   logic signed [24:0] scaled;
   logic [16:0] mag;
   logic [32:0] sum_next;
   logic [15:0] sat_delta;
   logic [7:0] clamped;
   always_comb begin
      diff = $signed({9'd0, tgt}) - $signed({prod[15], prod});
      scaled = {{8{diff[16]}}, diff} <<< S;
      sat_delta = scaled > 25'sd32767 ? 16'h7FFF : scaled < -25'sd32768 ? 16'h8000 : scaled[15:0];
      mag = diff[16] ? $unsigned(-diff) : $unsigned(diff);
      sum_next = {1'b0, error_sum} + {16'd0, mag};
      clamped = product_data[15] ? 8'h00 : |product_data[14:8] ? 8'hFF : product_data[7:0];
   end
   assign product_ready = state == IDLE;
   assign target_ready = state == TGT;
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         prod <= '0;
         tgt <= '0;
         delta_valid <= 1'b0;
         delta_data <= '0;
         result_valid <= 1'b0;
         result_data <= '0;
         error_sum <= '0;
         sample_count <= '0;
      end else begin
         if (state == IDLE && product_valid) begin
            prod <= product_data;
            result_data <= train ? result_data : clamped;
            result_valid <= !train;
            state <= train ? TGT : RES;
         end
         if (state == RES && result_ready) begin
            result_valid <= 1'b0;
            state <= IDLE;
         end
         if (state == TGT && target_valid) begin
            tgt <= target_data;
            state <= CMP;
         end
         if (state == CMP) begin
            delta_data <= sat_delta;
            delta_valid <= 1'b1;
            error_sum <= sum_next[32] ? 32'hFFFF_FFFF : sum_next[31:0];
            sample_count <= &sample_count ? sample_count : sample_count + 16'd1;
            state <= DEL;
         end
         if (state == DEL && delta_ready) begin
            delta_valid <= 1'b0;
            state <= IDLE;
         end
         // clear overrides a same-cycle statistics update
         if (clear) begin
            error_sum <= '0;
            sample_count <= '0;
         end
      end
   end
endmodule

// File: doc/objective.md
# objective

Output-layer training endpoint that closes the loop for a `node`. It consumes a node's 16-bit product stream. In inference mode it emits the product clamped to an 8-bit result. In training mode it pairs each product with an 8-bit target, computes the signed, saturated error term and returns it on the node's delta interface. It also keeps running error statistics for monitoring convergence.

## Interface
- `S`, default 0: left-shift gain applied to the raw error before saturation (0..8).
- `clock`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `train`  in  1  mode select, sampled on the product handshake.
- `clear`  in  1  synchronous clear of statistics.
- `product_valid`  in  1  product offered.
- `product_data`  in  16  signed product, fixed point with 8 fractional bits relative to the target scale.
- `product_ready`  out  1  product accepted.
- `target_valid`  in  1  target offered.
- `target_data`  in  8  unsigned target.
- `target_ready`  out  1  target accepted.
- `delta_valid`  out  1  error term offered to the node.
- `delta_data`  out  16  signed saturated error term.
- `delta_ready`  in  1  node accepts the error term.
- `result_valid`  out  1  inference result offered.
- `result_data`  out  8  clamped product.
- `result_ready`  in  1  downstream accepts the result.
- `error_sum`  out  32  saturating sum of absolute pre-shift errors.
- `sample_count`  out  16  number of training samples, saturating at 0xFFFF.

## Operation
- States: IDLE, RES, TGT, CMP, DEL.
- IDLE:
  - `product_ready=1`.
  - On `product_valid`, latch `product_data` and `train`.
  - Next state is TGT if `train=1`, else RES.
- RES:
  - `result_valid=1`.
  - `result_data = 0` if product < 0; 255 if product > 255; otherwise `product[7:0]`.
  - On `result_ready`, go to IDLE.
- TGT:
  - `target_ready=1`.
  - On `target_valid`, latch the target and go to CMP.
- CMP (exactly one cycle):
  - `diff = zero-extended target − sign-extended product`, 17-bit signed.
  - `delta = sat16(diff <<< S)`: saturate to 0x7FFF or 0x8000; no wrap.
  - `error_sum += |diff|`, saturating at 0xFFFFFFFF.
  - `sample_count += 1`, saturating.
  - Next state is DEL.
- DEL:
  - `delta_valid=1`, `delta_data` held stable.
  - On `delta_ready`, go to IDLE.
- Ready signals are combinational decodes of state. Valid and data outputs are registered.
- Held-stable rule: `delta_data` and `result_data` must not change while the corresponding valid is high.
- A mode change on `train` outside IDLE has no effect until the next product handshake.
- Inputs never affect state outside their state's ready window:
  - `target_valid` while not in TGT is ignored, with no target consumed.
  - `product_valid` outside IDLE is not accepted.
- `clear`:
  - Zeroes `error_sum` and `sample_count` the next cycle.
  - If asserted in the CMP cycle, clear wins: both counters read 0 afterwards.
  - The delta is still produced normally.
- `reset`:
  - Forces IDLE, `delta_valid=0`, `result_valid=0`, `error_sum=0`, `sample_count=0`, `delta_data=0`, `result_data=0`.
  - Any latched product or target is discarded; a transaction in flight is abandoned.

## Timing
- Product handshake at cycle N, training mode:
  - `target_ready` is high from N+1.
  - If the target handshakes at N+1, CMP is at N+2 and `delta_valid` rises at N+3.
- Minimum training turnaround: 4 cycles per sample when `delta_ready` is held high. The next product can be accepted at N+4.
- Product handshake at cycle N, inference mode:
  - `result_valid` rises at N+1.
  - With `result_ready` high, the next product can be accepted at N+2.
- Statistics outputs update at the edge ending CMP and are visible the cycle `delta_valid` rises.
- Backpressure on delta or result holds the FSM indefinitely with outputs stable.
- `product_ready` stays low throughout.
- No combinational path from `*_valid` to `*_ready`.

## Test plan
- Reset, then idle for 5 cycles. Required: `product_ready=1`, `target_ready=0`, all valids 0, `error_sum=0`, `sample_count=0`.
- Training, S=0, product 0x0040, target 200, `delta_ready` high:
  - `delta_data=0x0088` at N+3.
  - `error_sum=136`, `sample_count=1`.
  - Next product is accepted at N+4.
- Saturation, S=0:
  - Product 0x8000, target 255 → delta 0x7FFF, `error_sum` +33023.
  - Product 0x7FFF, target 0 → delta 0x8001.
  - With S=2: product 0x0000, target 255 → 0x03FC.
  - With S=8: product 0x0000, target 255 → 0x7FFF.
- Inference:
  - Products 0x0123, 0xFFF0, 0x0050 → results 0xFF, 0x00, 0x50.
  - With `result_ready` low for 3 cycles: `result_data` stays stable and `product_ready` stays 0.
- Protocol edges:
  - `target_valid` pulsed while in IDLE is not consumed.
  - `delta_ready` low for 4 cycles holds `delta_data` constant.
  - `clear` during CMP leaves `error_sum=0` and `sample_count=0` while the delta is still issued.
- Reset asserted while in DEL and while in TGT. Required: the next cycle is IDLE with valids 0 and statistics zero, and a fresh product/target pair then yields the correct delta.
